// File: rtl/turn_control.sv
// Player-input front end for the chess clock: synchronises and debounces the buttons,
// sequences turns, latches resignations and counts completed full moves.
module turn_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned COUNT_WIDTH     = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_start,
  input  logic                   btn_white,
  input  logic                   btn_black,
  input  logic                   resign_white,
  input  logic                   resign_black,
  input  logic [1:0]             timeout,
  output logic                   move,
  output logic                   turn,
  output logic [1:0]             checkmate,
  output logic [COUNT_WIDTH-1:0] move_count
);

  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned N_BTN  = 3;
  localparam int unsigned N_RAW  = 5;
  localparam int unsigned BTN_ST = 0;
  localparam int unsigned BTN_WH = 1;
  localparam int unsigned BTN_BK = 2;
  localparam int unsigned RSG_WH = 3;
  localparam int unsigned RSG_BK = 4;

  typedef enum logic [1:0] {
    S_SETUP = 2'd0,
    S_WHITE = 2'd1,
    S_BLACK = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t           r_state;
  logic [N_RAW-1:0] w_raw;
  logic [N_RAW-1:0] r_sync1;
  logic [N_RAW-1:0] r_sync2;
  logic [N_BTN-1:0] w_db;
  logic [N_BTN-1:0] r_db_d;
  logic [N_BTN-1:0] w_press;
  logic [1:0]       w_resign;
  logic             w_side_press;

  assign w_raw = {resign_black, resign_white, btn_black, btn_white, btn_start};

  // Two-flop synchroniser for every asynchronous input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Level is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  for (genvar g = 0; g < N_BTN; g++) begin : g_db
    logic [CNT_W-1:0] r_cnt;
    logic             r_lvl;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync2[g] != r_lvl) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_lvl <= r_sync2[g];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_db[g] = r_lvl;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_d <= '0;
    end else begin
      r_db_d <= w_db;
    end
  end

  assign w_press      = w_db & ~r_db_d;
  assign w_resign     = {r_sync2[RSG_BK], r_sync2[RSG_WH]};
  assign w_side_press = turn ? w_press[BTN_BK] : w_press[BTN_WH];

  // Turn sequencer; priority timeout > resign > press of the side to move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_SETUP;
      move       <= 1'b0;
      turn       <= 1'b0;
      checkmate  <= 2'b00;
      move_count <= '0;
    end else begin
      move <= 1'b0;
      case (r_state)
        S_SETUP: begin
          turn <= 1'b0;
          if (w_press[BTN_ST]) begin
            move    <= 1'b1;
            r_state <= S_WHITE;
          end
        end
        S_WHITE, S_BLACK: begin
          if (timeout != 2'b00) begin
            r_state <= S_OVER;
          end else if (w_resign != 2'b00) begin
            checkmate <= w_resign;
            r_state   <= S_OVER;
          end else if (w_side_press) begin
            move <= 1'b1;
            if (r_state == S_WHITE) begin
              turn    <= 1'b1;
              r_state <= S_BLACK;
            end else begin
              turn    <= 1'b0;
              r_state <= S_WHITE;
              if (move_count != '1) begin
                move_count <= move_count + COUNT_WIDTH'(1);
              end
            end
          end
        end
        default: begin
          r_state <= S_OVER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turn_control.sv
// Randomised and directed bench for turn_control, checked cycle by cycle against
// a rule-level model of synchronisation, debounce and turn order.
module tb_turn_control;

  localparam int unsigned D   = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned HD  = D + 2;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          btn_start, btn_white, btn_black;
  logic          resign_white, resign_black;
  logic [1:0]    timeout;
  logic          move;
  logic          turn;
  logic [1:0]    checkmate;
  logic [CW-1:0] move_count;

  turn_control #(.DEBOUNCE_CYCLES(D), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_white(btn_white), .btn_black(btn_black),
    .resign_white(resign_white), .resign_black(resign_black),
    .timeout(timeout),
    .move(move), .turn(turn), .checkmate(checkmate), .move_count(move_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_move   = 0;

  // Model: raw sample history (index 0 newest), debounced levels, game phase.
  bit       h [5][HD];
  bit       m_db [3];
  bit       m_rose [3];
  int       m_phase;  // 0 setup, 1 playing, 2 over
  bit       m_turn;
  bit [1:0] m_cm;
  int       m_cnt;
  bit       m_move;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < int'(HD); j++) h[i][j] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      m_db[b]   = 1'b0;
      m_rose[b] = 1'b0;
    end
    m_phase = 0; m_turn = 1'b0; m_cm = 2'b00; m_cnt = 0; m_move = 1'b0;
  endtask

  // One clock edge of the model; raw/to are the levels present at that edge.
  task automatic model_step(input bit [4:0] raw, input bit [1:0] to);
    bool_t_dummy: begin end
    for (int i = 0; i < 5; i++) begin
      for (int j = int'(HD) - 1; j > 0; j--) h[i][j] = h[i][j-1];
      h[i][0] = raw[i];
    end
    m_move = 1'b0;
    // A raw level reaches the logic two edges after it is sampled.
    if (m_phase == 0) begin
      m_turn = 1'b0;
      if (m_rose[0]) begin m_move = 1'b1; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (to != 2'b00) m_phase = 2;
      else if (h[3][2] || h[4][2]) begin m_cm = {h[4][2], h[3][2]}; m_phase = 2; end
      else if (m_rose[1 + int'(m_turn)]) begin
        m_move = 1'b1;
        if (m_turn && m_cnt < MAXC) m_cnt++;
        m_turn = ~m_turn;
      end
    end
    // Debounced level flips once the last D synchronised samples all disagree with it.
    for (int b = 0; b < 3; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = 2; j < int'(HD); j++) if (h[b][j] == m_db[b]) all_diff = 1'b0;
      m_rose[b] = all_diff && !m_db[b];
      if (all_diff) m_db[b] = ~m_db[b];
    end
  endtask

  task automatic tick(input bit [4:0] raw, input bit [1:0] to);
    {resign_black, resign_white, btn_black, btn_white, btn_start} = raw;
    timeout = to;
    model_step(raw, to);
    @(negedge clk);
    if (move) n_move++;
    check("move", int'(move), int'(m_move));
    check("turn", int'(turn), int'(m_turn));
    check("checkmate", int'(checkmate), int'(m_cm));
    check("move_count", int'(move_count), m_cnt);
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic areset();
    #2 reset = 1'b0;
    #1;
    check("rst_move", int'(move), 0);
    check("rst_turn", int'(turn), 0);
    check("rst_checkmate", int'(checkmate), 0);
    check("rst_move_count", int'(move_count), 0);
    #1 reset = 1'b1;
    model_clear();
  endtask

  task automatic press(input int idx);
    bit [4:0] v;
    v = 5'b0;
    v[idx] = 1'b1;
    for (int c = 0; c < int'(D) + 4; c++) tick(v, 2'b00);
    for (int c = 0; c < int'(D) + 4; c++) tick(5'b0, 2'b00);
  endtask

  initial begin
    int found;
    bit [2:0] lvl;
    int hold [3];
    bit [1:0] rsg;
    int over_cycles;
    bit [4:0] v;
    bit [1:0] to;

    reset = 1'b0;
    {btn_start, btn_white, btn_black, resign_white, resign_black} = 5'b0;
    timeout = 2'b00;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Bounces with high runs of at most 3 cycles never register.
    n_move = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) tick(5'b00001, 2'b00);
      for (int c = 0; c < 3; c++) tick(5'b00000, 2'b00);
    end
    check("bounce_pulses", n_move, 0);
    areset();

    // Clean start press: pulse on the seventh edge after the first sample.
    found = 0;
    for (int c = 1; c <= 12; c++) begin
      tick(5'b00001, 2'b00);
      if (move && found == 0) found = c;
    end
    check("start_latency", found, int'(D) + 3);
    for (int c = 0; c < 8; c++) tick(5'b0, 2'b00);

    // Black out of turn, then three full moves, then saturation.
    n_move = 0;
    press(2);
    check("black_out_of_turn", n_move, 0);
    for (int r = 0; r < 3; r++) begin press(1); press(2); end
    check("six_pulses", n_move, 6);
    check("count_after_three", int'(move_count), 3);
    for (int r = 0; r < 2; r++) begin press(1); press(2); end
    check("count_saturated", int'(move_count), MAXC);

    // Resign by white during black's turn freezes the game.
    press(1);
    check("turn_black", int'(turn), 1);
    for (int c = 0; c < 3; c++) tick(5'b01000, 2'b00);
    check("resign_white_cm", int'(checkmate), 1);
    n_move = 0;
    press(1); press(2); press(0);
    check("over_frozen_pulses", n_move, 0);
    check("over_frozen_turn", int'(turn), 1);
    areset();

    // Timeout on the very edge a white press would act.
    press(0);
    n_move = 0;
    for (int c = 1; c < int'(D) + 3; c++) tick(5'b00010, 2'b00);
    tick(5'b00010, 2'b01);
    check("to_vs_press_move", int'(move), 0);
    for (int c = 0; c < 8; c++) tick(5'b00010, 2'b00);
    check("to_vs_press_pulses", n_move, 0);
    check("to_vs_press_turn", int'(turn), 0);
    check("to_vs_press_cm", int'(checkmate), 0);
    areset();

    // Simultaneous resignations give a draw.
    press(0);
    for (int c = 0; c < 3; c++) tick(5'b11000, 2'b00);
    check("draw_cm", int'(checkmate), 3);
    areset();

    // Mid-game asynchronous reset, then player presses need a new start.
    press(0);
    press(1); press(2); press(1); press(2); press(1);
    check("pre_rst_count", int'(move_count), 2);
    check("pre_rst_turn", int'(turn), 1);
    areset();
    n_move = 0;
    press(1); press(2);
    check("no_start_pulses", n_move, 0);
    press(0); press(1);
    check("after_start_turn", int'(turn), 1);

    // Randomised play with bounces, resigns, timeouts and resets.
    areset();
    lvl = 3'b0; rsg = 2'b0; over_cycles = 0;
    for (int b = 0; b < 3; b++) hold[b] = $urandom_range(1, 9);
    for (int c = 0; c < 6000; c++) begin
      for (int b = 0; b < 3; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          lvl[b] = ~lvl[b];
          hold[b] = lvl[b] ? $urandom_range(1, 10) : $urandom_range(1, 12);
        end
      end
      if ($urandom_range(0, 299) == 0) rsg = 2'($urandom_range(1, 3));
      to = ($urandom_range(0, 249) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v = {rsg, lvl};
      tick(v, to);
      over_cycles = (m_phase == 2) ? over_cycles + 1 : 0;
      if (over_cycles > 20 || $urandom_range(0, 1999) == 0) begin
        areset();
        rsg = 2'b0;
        over_cycles = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/turn_control.md
Name: turn_control

Overview:
- Player-input front end that sits directly upstream of the chess clock. It produces the clock's `move`, `turn` and `checkmate` inputs and consumes its `timeout` output.
- Synchronises and debounces the start button and the two player clock buttons, then runs the turn-order state machine.
- Latches resignations and counts completed full moves for the display and game-record logic.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles before a synchronised button level is accepted (10 ms at 100 MHz); minimum legal value 2.
- COUNT_WIDTH, 10, width of move_count.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- btn_start  input  1  raw start pushbutton, asynchronous.
- btn_white  input  1  raw white clock button, asynchronous; white presses it to end white's turn.
- btn_black  input  1  raw black clock button, asynchronous.
- resign_white  input  1  raw resign/mated switch for white, asynchronous level.
- resign_black  input  1  raw resign/mated switch for black, asynchronous level.
- timeout  input  2  from chess clock, synchronous to clk; bit0 = white flagged, bit1 = black flagged.
- move  output  1  one-cycle pulse per accepted start or turn-ending press.
- turn  output  1  side to move: 0 = white, 1 = black.
- checkmate  output  2  bit0 = white lost by resign/mate, bit1 = black lost; 2'b11 = draw.
- move_count  output  COUNT_WIDTH  completed full moves.

Behaviour:
- Reset (reset=0, asynchronous):
  - move=0, turn=0, checkmate=0, move_count=0.
  - State = S_SETUP.
  - All synchroniser flops, debounced levels and debounce counters = 0.
- Reset deassertion mid-game restarts from S_SETUP; nothing is retained.
- Input synchronisation: every raw input passes through a 2-flop synchroniser. Resign inputs are synchronised only, not debounced. timeout is used directly.
- Debounce, one instance per button:
  - A counter runs while the synchronised level differs from the debounced level.
  - The counter clears whenever the two levels match.
  - When the counter has seen DEBOUNCE_CYCLES consecutive differing cycles, the debounced level takes the new value and the counter clears.
- Press = rising edge of a debounced level. Releases generate nothing.
- Latency: for a clean raw high held from cycle 0, the press acts (move pulse, turn update) at cycle DEBOUNCE_CYCLES+3. Any bounce shorter than DEBOUNCE_CYCLES cycles produces no press.
- State machine:
  - S_SETUP: turn=0. A start press causes a move pulse and a transition to S_WHITE. Player buttons and resigns are ignored.
  - S_WHITE:
    - A white press causes a move pulse, turn becomes 1, and the state goes to S_BLACK.
    - A black press is ignored.
  - S_BLACK:
    - A black press causes a move pulse, turn becomes 0, and move_count increments (saturating at all-ones). The state goes to S_WHITE.
    - A white press is ignored.
  - S_WHITE/S_BLACK, resign:
    - Synchronised resign_white=1 sets checkmate=2'b01; synchronised resign_black=1 sets checkmate=2'b10; both in the same cycle set checkmate=2'b11.
    - The state then goes to S_OVER.
  - S_WHITE/S_BLACK, timeout: timeout≠0 goes to S_OVER with checkmate unchanged.
  - S_OVER: all outputs are frozen, including turn and move_count, and all inputs are ignored until reset.
  - S_WHITE and S_BLACK stay put on no event.
- Priority within one cycle, highest first:
  1. timeout
  2. resign
  3. press of the side to move
- A press that coincides with a timeout or resign produces no move pulse and no turn change.
- Simultaneous white and black presses: only the side-to-move press is honoured.
- The start button is ignored outside S_SETUP.
- move is registered, high for exactly one cycle per accepted press, and never high in S_OVER.
- All outputs are registered.

Test Plan:
- DEBOUNCE_CYCLES=4, reset, then btn_start high from cycle 0 → move pulse at cycle 7 only, turn=0, state S_WHITE; btn_start bouncing with high runs of at most 3 cycles → no pulse.
- Start, then white press, then black press, ×3 → six move pulses; turn alternates 1,0,1,0,1,0; move_count ends at 3; black presses during white's turn produce no pulse.
- COUNT_WIDTH=2: five full moves → move_count sequence 1,2,3,3,3 (saturates).
- During S_BLACK: resign_white=1 → checkmate=2'b01 within 3 cycles. Further button presses and turn are frozen; move never pulses.
- During S_WHITE: timeout=2'b01 in the same cycle that debounced white press edge acts → no move pulse, turn stays 0, checkmate=0, S_OVER; resign_white and resign_black raised together in a fresh game → checkmate=2'b11.
- reset pulsed low asynchronously (between clock edges) mid-game with move_count=2 and turn=1 → all outputs 0 immediately; the next start press is required before player presses are honoured.
